// File: rtl/ppu_write_arbiter.sv
// ppu_write_arbiter: merges CORES_COUNT per-core pixel FIFOs onto one Avalon-MM write master, round-robin.
// Latency: push sampled at edge N, output register loaded at edge N+1, so fb_write is high two edges after input.
// Backpressure: fb_waitrequest freezes the output register and stops pops; stall rises when any FIFO has one free entry left.
// Optional: define PPU_ARB_STATS_EN to build the stat_writes / stat_wait_cycles counters (tied to 0 otherwise).
module ppu_write_arbiter #(
   parameter int CORES_COUNT   = 10,
   parameter int COLOR_WIDTH   = 16,
   parameter int BUFFER_ADDR_W = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int REGION_BYTES  = 192000
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [CORES_COUNT*COLOR_WIDTH-1:0]   ppu_data,
   input  logic [CORES_COUNT*BUFFER_ADDR_W-1:0] ppu_address,
   input  logic [CORES_COUNT-1:0]               ppu_valid,
   input  logic [BUFFER_ADDR_W-1:0]             fb_base,
   output logic                                 stall,
   output logic [BUFFER_ADDR_W-1:0]             fb_address,
   output logic [COLOR_WIDTH-1:0]               fb_writedata,
   output logic                                 fb_write,
   input  logic                                 fb_waitrequest,
   output logic                                 idle,
   output logic                                 overflow,
   input  logic                                 clear,
   output logic [31:0]                          stat_writes,
   output logic [31:0]                          stat_wait_cycles
);
   localparam int GW  = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;
   localparam int GW1 = GW + 1;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;

   typedef struct packed {
      logic [COLOR_WIDTH-1:0]   data;
      logic [BUFFER_ADDR_W-1:0] addr;
   } entry_t;

   entry_t                   head       [CORES_COUNT];
   logic [CW-1:0]            count      [CORES_COUNT];
   logic [BUFFER_ADDR_W-1:0] region_off [CORES_COUNT];
   logic [CORES_COUNT-1:0]   nonempty;
   logic [CORES_COUNT-1:0]   near_full;
   logic [CORES_COUNT-1:0]   push;
   logic [CORES_COUNT-1:0]   pop;
   logic [CORES_COUNT-1:0]   drop;
   logic [GW-1:0]            last_grant;
   logic [GW-1:0]            grant_idx;
   logic [GW1-1:0]           cand;
   logic                     grant_vld;
   logic                     loadable;
   entry_t                   grant_entry;
   logic [BUFFER_ADDR_W-1:0] next_address;

   // The output register may take a new entry when empty or when the slave accepts the current one.
   assign loadable = !fb_write || !fb_waitrequest;

   for (genvar gi = 0; gi < CORES_COUNT; gi++) begin : g_core
      entry_t        mem [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;
      logic [CW-1:0] occ;
      entry_t        in_entry;

      assign in_entry.data  = ppu_data[gi*COLOR_WIDTH +: COLOR_WIDTH];
      assign in_entry.addr  = ppu_address[gi*BUFFER_ADDR_W +: BUFFER_ADDR_W];
      // Region base is an elaboration-time constant per core, so no multiplier is built.
      assign region_off[gi] = BUFFER_ADDR_W'(64'(gi) * 64'(REGION_BYTES));
      assign count[gi]      = occ;
      assign head[gi]       = mem[rd_ptr];
      assign nonempty[gi]   = (occ != '0);
      assign near_full[gi]  = (occ >= CW'(FIFO_DEPTH - 1));
      assign pop[gi]        = loadable && grant_vld && (grant_idx == GW'(gi));
      // A full FIFO still accepts when it is being drained in the same cycle.
      assign push[gi]       = ppu_valid[gi] && ((occ < CW'(FIFO_DEPTH)) || pop[gi]);
      assign drop[gi]       = ppu_valid[gi] && !push[gi];

      // Entry storage; occupancy guards every read so the array needs no reset.
      always_ff @(posedge clk) begin
         if (push[gi]) begin
            mem[wr_ptr] <= in_entry;
         end
      end

      // Pointer and occupancy bookkeeping for this core's FIFO.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
         end else begin
            if (push[gi]) wr_ptr <= wr_ptr + PW'(1);
            if (pop[gi])  rd_ptr <= rd_ptr + PW'(1);
            case ({push[gi], pop[gi]})
               2'b10:   occ <= occ + CW'(1);
               2'b01:   occ <= occ - CW'(1);
               default: occ <= occ;
            endcase
         end
      end
   end

   // Round-robin pick: first non-empty FIFO after last_grant; scanning far-to-near lets the nearest win.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = CORES_COUNT; k >= 1; k--) begin
         cand = {1'b0, last_grant} + GW1'(k);
         if (cand >= GW1'(CORES_COUNT)) begin
            cand = cand - GW1'(CORES_COUNT);
         end
         if (nonempty[cand[GW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[GW-1:0];
         end
      end
   end

   assign grant_entry  = head[grant_idx];
   assign next_address = fb_base + region_off[grant_idx] + grant_entry.addr;

   // Output register: loads the granted entry, holds everything while the slave stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_write     <= 1'b0;
         fb_address   <= '0;
         fb_writedata <= '0;
         last_grant   <= GW'(CORES_COUNT - 1);
      end else if (loadable) begin
         fb_write <= grant_vld;
         if (grant_vld) begin
            fb_address   <= next_address;
            fb_writedata <= grant_entry.data;
            last_grant   <= grant_idx;
         end
      end
   end

   assign stall = |near_full;
   assign idle  = (nonempty == '0) && !fb_write;

   // Sticky drop flag; a drop in the clearing cycle keeps it set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (|drop) begin
         overflow <= 1'b1;
      end else if (clear) begin
         overflow <= 1'b0;
      end
   end

`ifdef PPU_ARB_STATS_EN
   // Completed-write and wait-cycle counters, wrapping at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_writes      <= '0;
         stat_wait_cycles <= '0;
      end else if (clear) begin
         stat_writes      <= '0;
         stat_wait_cycles <= '0;
      end else begin
         if (fb_write && !fb_waitrequest) stat_writes      <= stat_writes + 32'd1;
         if (fb_write && fb_waitrequest)  stat_wait_cycles <= stat_wait_cycles + 32'd1;
      end
   end
`else
   assign stat_writes      = '0;
   assign stat_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_ppu_write_arbiter.sv
// tb_ppu_write_arbiter: directed and random traffic against a queue-based reference of the arbiter.
// Expected writes are queued when the reference grants; a negedge monitor pops them on each completed write.
`timescale 1ns/1ps
module tb_ppu_write_arbiter;
   localparam int NC     = 10;
   localparam int CWD    = 16;
   localparam int AW     = 32;
   localparam int DEPTH  = 4;
   localparam int REGION = 192000;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NC*CWD-1:0] ppu_data = '0;
   logic [NC*AW-1:0]  ppu_address = '0;
   logic [NC-1:0]     ppu_valid = '0;
   logic [AW-1:0]     fb_base = '0;
   logic              fb_waitrequest = 1'b0;
   logic              clear = 1'b0;
   logic              stall, fb_write, idle, overflow;
   logic [AW-1:0]     fb_address;
   logic [CWD-1:0]    fb_writedata;
   logic [31:0]       stat_writes, stat_wait_cycles;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [47:0] mq [NC][$];
   logic [47:0] exp_q [$];
   logic [15:0] seen_q [$];
   bit          m_write = 1'b0;
   int          m_last = NC - 1;
   bit          m_ovf = 1'b0;
   logic [31:0] m_writes = '0;
   logic [31:0] m_waits = '0;
   int          sz [NC];
   bit          popped [NC];
   int          g, c;
   bit          drp;
   logic [47:0] e, e_mon;

   always #5 clk = ~clk;

   ppu_write_arbiter dut (
      .clk(clk), .reset(reset), .ppu_data(ppu_data), .ppu_address(ppu_address),
      .ppu_valid(ppu_valid), .fb_base(fb_base), .stall(stall), .fb_address(fb_address),
      .fb_writedata(fb_writedata), .fb_write(fb_write), .fb_waitrequest(fb_waitrequest),
      .idle(idle), .overflow(overflow), .clear(clear), .stat_writes(stat_writes),
      .stat_wait_cycles(stat_wait_cycles)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic bit m_stall();
      for (int i = 0; i < NC; i++) if (mq[i].size() >= DEPTH - 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_empty();
      for (int i = 0; i < NC; i++) if (mq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Reference: per-core queues, one grant per loadable cycle, region base by arithmetic.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NC; i++) mq[i].delete();
         exp_q.delete();
         m_write  = 1'b0;
         m_last   = NC - 1;
         m_ovf    = 1'b0;
         m_writes = '0;
         m_waits  = '0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            sz[i]     = mq[i].size();
            popped[i] = 1'b0;
         end
         if (m_write && !fb_waitrequest) m_writes = m_writes + 32'd1;
         if (m_write && fb_waitrequest)  m_waits  = m_waits + 32'd1;
         if (clear) begin
            m_writes = '0;
            m_waits  = '0;
         end
         if (!m_write || !fb_waitrequest) begin
            g = -1;
            for (int k = 1; k <= NC; k++) begin
               c = (m_last + k) % NC;
               if (g < 0 && sz[c] > 0) g = c;
            end
            if (g >= 0) begin
               e = mq[g].pop_front();
               popped[g] = 1'b1;
               exp_q.push_back({e[47:32], fb_base + AW'(g * REGION) + e[31:0]});
               m_write = 1'b1;
               m_last  = g;
            end else begin
               m_write = 1'b0;
            end
         end
         drp = 1'b0;
         for (int i = 0; i < NC; i++) begin
            if (ppu_valid[i]) begin
               if (sz[i] < DEPTH || popped[i])
                  mq[i].push_back({ppu_data[i*CWD +: CWD], ppu_address[i*AW +: AW]});
               else
                  drp = 1'b1;
            end
         end
         if (drp) m_ovf = 1'b1;
         else if (clear) m_ovf = 1'b0;
      end
   end

   // Monitor: status every cycle, write contents whenever a write completes.
   always @(negedge clk) begin
      if (!reset) begin
         check("fb_write", fb_write, m_write);
         check("stall", stall, m_stall());
         check("idle", idle, m_empty() && !m_write);
         check("overflow", overflow, m_ovf);
`ifdef PPU_ARB_STATS_EN
         check("stat_writes", stat_writes, m_writes);
         check("stat_wait_cycles", stat_wait_cycles, m_waits);
`else
         check("stat_writes", stat_writes, 0);
         check("stat_wait_cycles", stat_wait_cycles, 0);
`endif
         if (fb_write === 1'b1 && fb_waitrequest === 1'b0) begin
            check("write_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e_mon = exp_q.pop_front();
               check("fb_address", fb_address, e_mon[31:0]);
               check("fb_writedata", fb_writedata, e_mon[47:32]);
            end
            seen_q.push_back(fb_writedata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_px(input int i, input logic [15:0] d, input logic [31:0] a);
      ppu_data[i*CWD +: CWD] = d;
      ppu_address[i*AW +: AW] = a;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (idle !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check("idle_within_budget", idle, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit pair_ok;
      step();
      step();
      check("rst_fb_write", fb_write, 0);
      check("rst_fb_address", fb_address, 0);
      check("rst_fb_writedata", fb_writedata, 0);
      check("rst_overflow", overflow, 0);
      check("rst_idle", idle, 1);
      check("rst_stall", stall, 0);
      check("rst_stat_writes", stat_writes, 0);
      check("rst_stat_wait", stat_wait_cycles, 0);
      reset = 1'b0;
      step();

      // single pulse, two-edge latency
      fb_base = 32'h1000;
      set_px(3, 16'hABCD, 32'h10);
      ppu_valid[3] = 1'b1;
      step();
      ppu_valid = '0;
      check("t1_no_write_yet", fb_write, 0);
      step();
      check("t1_write", fb_write, 1);
      check("t1_addr", fb_address, 32'h1000 + 3 * 192000 + 32'h10);
      check("t1_data", fb_writedata, 16'hABCD);
      check("t1_busy", idle, 0);
      step();
      check("t1_idle", idle, 1);

      // all cores from reset, then again, then a 2/7 pair after a grant to 2
      do_reset();
      for (int r = 0; r < 2; r++) begin
         seen_q.delete();
         for (int i = 0; i < NC; i++) set_px(i, 16'(16'h0A00 + 256 * r + i), 32'(i * 4));
         ppu_valid = '1;
         step();
         ppu_valid = '0;
         wait_idle(40);
         check("t2_count", seen_q.size(), NC);
         for (int k = 0; k < NC; k++)
            if (k < seen_q.size()) check($sformatf("t2_order%0d_%0d", r, k), seen_q[k], 16'h0A00 + 256 * r + k);
      end
      set_px(2, 16'h0C02, 32'h20);
      ppu_valid[2] = 1'b1;
      step();
      ppu_valid = '0;
      wait_idle(20);
      seen_q.delete();
      set_px(2, 16'h0D02, 32'h24);
      set_px(7, 16'h0D07, 32'h28);
      ppu_valid[2] = 1'b1;
      ppu_valid[7] = 1'b1;
      step();
      ppu_valid = '0;
      wait_idle(20);
      pair_ok = (seen_q.size() == 2);
      check("t3_pair_count", seen_q.size(), 2);
      if (pair_ok) begin
         check("t3_first_is_7", seen_q[0], 16'h0D07);
         check("t3_second_is_2", seen_q[1], 16'h0D02);
      end

      // stall threshold under waitrequest, one-cycle lag absorbed
      seen_q.delete();
      fb_waitrequest = 1'b1;
      n = 0;
      ppu_valid[0] = 1'b1;
      while (n < 20) begin
         set_px(0, 16'(16'h0100 + n), 32'(n * 2));
         step();
         n++;
         if (stall === 1'b1) break;
      end
      check("t4_pushes_until_stall", n, 4);
      set_px(0, 16'(16'h0100 + n), 32'(n * 2));
      step();
      n++;
      ppu_valid = '0;
      check("t4_stall_held", stall, 1);
      check("t4_no_overflow", overflow, 0);
      fb_waitrequest = 1'b0;
      wait_idle(40);
      check("t4_drained", seen_q.size(), 5);
      for (int k = 0; k < 5; k++)
         if (k < seen_q.size()) check($sformatf("t4_order%0d", k), seen_q[k], 16'h0100 + k);

      // overflow with output register already busy, then clear
      seen_q.delete();
      fb_waitrequest = 1'b1;
      set_px(1, 16'h1111, 32'h40);
      ppu_valid[1] = 1'b1;
      step();
      ppu_valid = '0;
      step();
      check("t5_reg_busy", fb_write, 1);
      ppu_valid[5] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         set_px(5, 16'(16'h0500 + k), 32'(k * 2));
         step();
      end
      ppu_valid = '0;
      check("t5_overflow", overflow, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t5_cleared", overflow, 0);
      fb_waitrequest = 1'b0;
      wait_idle(40);
      check("t5_written", seen_q.size(), 5);
      if (seen_q.size() == 5) begin
         check("t5_first", seen_q[0], 16'h1111);
         for (int k = 0; k < 4; k++) check($sformatf("t5_core5_%0d", k), seen_q[k + 1], 16'h0500 + k);
      end

      // statistics: 8 writes, 3 wait cycles
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 8; i++) set_px(i, 16'(16'h0600 + i), 32'(i * 4));
      ppu_valid = 10'h0FF;
      step();
      ppu_valid = '0;
      fb_waitrequest = 1'b1;
      repeat (4) step();
      fb_waitrequest = 1'b0;
      wait_idle(40);
`ifdef PPU_ARB_STATS_EN
      check("t6_stat_writes", stat_writes, 8);
      check("t6_stat_wait", stat_wait_cycles, 3);
`else
      check("t6_stat_writes_tied", stat_writes, 0);
      check("t6_stat_wait_tied", stat_wait_cycles, 0);
`endif

      // reset mid-burst discards queued pixels
      seen_q.delete();
      fb_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) set_px(i, 16'(16'h0700 + i), 32'(i));
      ppu_valid = 10'h007;
      step();
      ppu_valid = '0;
      step();
      check("t7_busy", fb_write, 1);
      reset = 1'b1;
      #1;
      check("t7_rst_write", fb_write, 0);
      check("t7_rst_idle", idle, 1);
      check("t7_rst_stall", stall, 0);
      step();
      reset = 1'b0;
      fb_waitrequest = 1'b0;
      repeat (10) step();
      check("t7_discarded", seen_q.size(), 0);

      // random traffic honouring stall
      for (int cyc = 0; cyc < 1500; cyc++) begin
         fb_waitrequest = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) fb_base = $urandom;
         clear = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < NC; i++) set_px(i, 16'($urandom), $urandom);
         ppu_valid = (stall === 1'b1) ? '0 : (NC'($urandom) & NC'($urandom));
         step();
      end

      // random traffic ignoring stall, heavy waitrequest
      for (int cyc = 0; cyc < 400; cyc++) begin
         fb_waitrequest = ($urandom_range(0, 3) != 0);
         clear = ($urandom_range(0, 31) == 0);
         for (int i = 0; i < NC; i++) set_px(i, 16'($urandom), $urandom);
         ppu_valid = NC'($urandom);
         step();
      end

      ppu_valid = '0;
      clear = 1'b0;
      fb_waitrequest = 1'b0;
      step();
      wait_idle(200);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
